// File: rtl/dp_pkg.sv
// Shared types and constants for the dual-port point-multiplier arbiter.
package dp_pkg;

    localparam int DP_DATA_WIDTH = 192;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY,
        RESP
    } dp_state_e;

endpackage

// File: rtl/dp_arbiter_rr_sel.sv
// Two-way round-robin grant: the requester other than last_served wins a tie.
module dp_rr_sel (
    input  logic [1:0] req_valid,
    input  logic       last_served,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_served ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dp_arbiter.sv
// Arbitrates two requesters onto one point multiplier, one op at a time.
// Optional BUSY watchdog enabled by defining DP_ARB_TIMEOUT_EN.
module dp_arbiter
    import dp_pkg::*;
#(
    parameter int DATA_WIDTH     = DP_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [2*DATA_WIDTH-1:0] req_px,
    input  logic [2*DATA_WIDTH-1:0] req_py,
    input  logic [2*DATA_WIDTH-1:0] req_k,
    output logic                    core_in_valid,
    output logic [DATA_WIDTH-1:0]   core_px,
    output logic [DATA_WIDTH-1:0]   core_py,
    output logic [DATA_WIDTH-1:0]   core_k,
    input  logic                    core_out_valid,
    input  logic [DATA_WIDTH-1:0]   core_rx,
    input  logic [DATA_WIDTH-1:0]   core_ry,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_id,
    output logic [DATA_WIDTH-1:0]   rsp_rx,
    output logic [DATA_WIDTH-1:0]   rsp_ry,
    output logic                    rsp_err,
    output logic                    busy
);

    dp_state_e             state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic [DATA_WIDTH-1:0] px_q, px_d;
    logic [DATA_WIDTH-1:0] py_q, py_d;
    logic [DATA_WIDTH-1:0] k_q, k_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] ry_q, ry_d;
    logic [1:0]            grant;
    logic                  sel;

    dp_rr_sel u_rr_sel (
        .req_valid   (req_valid),
        .last_served (last_q),
        .grant       (grant)
    );

    assign sel = grant[1];

`ifdef DP_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          expired;

    assign expired = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        px_d    = px_q;
        py_d    = py_q;
        k_d     = k_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
`ifdef DP_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    state_d = ISSUE;
                    owner_d = sel;
                    px_d    = sel ? req_px[2*DATA_WIDTH-1:DATA_WIDTH]
                                  : req_px[DATA_WIDTH-1:0];
                    py_d    = sel ? req_py[2*DATA_WIDTH-1:DATA_WIDTH]
                                  : req_py[DATA_WIDTH-1:0];
                    k_d     = sel ? req_k[2*DATA_WIDTH-1:DATA_WIDTH]
                                  : req_k[DATA_WIDTH-1:0];
                end
            end
            ISSUE: begin
                state_d = BUSY;
`ifdef DP_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            BUSY: begin
                if (core_out_valid) begin
                    state_d = RESP;
                    rx_d    = core_rx;
                    ry_d    = core_ry;
`ifdef DP_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (expired) begin
                    // Watchdog abort: report an error with a zeroed result.
                    state_d = RESP;
                    rx_d    = '0;
                    ry_d    = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            px_q    <= '0;
            py_q    <= '0;
            k_q     <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            px_q    <= px_d;
            py_q    <= py_d;
            k_q     <= k_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
        end
    end

`ifdef DP_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign req_ready     = (state_q == IDLE) ? grant : 2'b00;
    assign core_in_valid = (state_q == ISSUE);
    assign core_px       = px_q;
    assign core_py       = py_q;
    assign core_k        = k_q;
    assign rsp_valid     = (state_q == RESP);
    assign rsp_id        = owner_q;
    assign rsp_rx        = rx_q;
    assign rsp_ry        = ry_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_dp_arbiter.sv
// Randomized scoreboard bench for dp_arbiter with a behavioural XOR core.
// Define DP_ARB_TIMEOUT_EN to exercise the watchdog abort path.
module tb_dp_arbiter;

    localparam int DW = 192;

    typedef struct {
        logic          id;
        logic [DW-1:0] rx;
        logic [DW-1:0] ry;
        logic          err;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      req_valid = 2'b00;
    logic [1:0]      req_ready;
    logic [2*DW-1:0] req_px, req_py, req_k;
    logic            core_in_valid;
    logic [DW-1:0]   core_px, core_py, core_k;
    logic            core_out_valid = 1'b0;
    logic [DW-1:0]   core_rx = '0, core_ry = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic            rsp_id;
    logic [DW-1:0]   rsp_rx, rsp_ry;
    logic            rsp_err;
    logic            busy;

    logic [DW-1:0] opx [2];
    logic [DW-1:0] opy [2];
    logic [DW-1:0] opk [2];

    assign req_px = {opx[1], opx[0]};
    assign req_py = {opy[1], opy[0]};
    assign req_k  = {opk[1], opk[0]};

    dp_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(50)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_px         (req_px),
        .req_py         (req_py),
        .req_k          (req_k),
        .core_in_valid  (core_in_valid),
        .core_px        (core_px),
        .core_py        (core_py),
        .core_k         (core_k),
        .core_out_valid (core_out_valid),
        .core_rx        (core_rx),
        .core_ry        (core_ry),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_rx         (rsp_rx),
        .rsp_ry         (rsp_ry),
        .rsp_err        (rsp_err),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   order[$];
    int   pops = 0;
    int   pulses = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   exp_lat = 12;
    bit   resp_seen = 1'b1;
    bit   issue_exp = 1'b0;
    bit   acc_flag [2] = '{1'b0, 1'b0};
    bit   last_m = 1'b1;
    bit   core_dead = 1'b0;
    logic [DW-1:0] iss_px, iss_py, iss_k;
    logic          last_id, last_err;
    logic [DW-1:0] last_rx, last_ry;
    int   remain [2] = '{0, 0};
    int   p_req = 0, p_drop = 0, p_rdy = 100;
    int   cm_cnt = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r;
        for (int w = 0; w < DW; w += 32) r[w +: 32] = $urandom;
        return r;
    endfunction

    // Behavioural multiplier: result = operands XOR k, 10 cycles after start.
    always @(negedge clk) begin
        if (core_in_valid) begin
            cm_cnt = 10;
            core_out_valid = 1'b0;
            core_rx = core_px ^ core_k;
            core_ry = core_py ^ core_k;
        end else if (cm_cnt > 0) begin
            cm_cnt--;
            if (cm_cnt == 0 && !core_dead) core_out_valid = 1'b1;
        end
    end

    // Monitor: samples mid-cycle, predicts grants and scores responses.
    always begin
        exp_t e;
        logic g;
        logic w;
        @(negedge clk);
        #2;
        if (rst_n) begin
            cyc++;
            chk("ready_onehot", DW'($onehot0(req_ready)), DW'(1));
            if (busy) chk("ready_busy", DW'(req_ready), '0);
            chk("issue_pulse", DW'(core_in_valid), DW'(issue_exp));
            if (core_in_valid) pulses++;
            if (issue_exp) begin
                chk("core_px", core_px, iss_px);
                chk("core_py", core_py, iss_py);
                chk("core_k", core_k, iss_k);
            end
            issue_exp = 1'b0;
            if (|(req_valid & req_ready)) begin
                g = req_ready[1];
                w = (req_valid == 2'b11) ? ~last_m : req_valid[1];
                chk("grant", DW'(g), DW'(w));
                e.id  = g;
                e.rx  = opx[g] ^ opk[g];
                e.ry  = opy[g] ^ opk[g];
                e.err = 1'b0;
`ifdef DP_ARB_TIMEOUT_EN
                if (core_dead) begin
                    e.rx  = '0;
                    e.ry  = '0;
                    e.err = 1'b1;
                end
`endif
                q.push_back(e);
                iss_px = opx[g];
                iss_py = opy[g];
                iss_k  = opk[g];
                issue_exp = 1'b1;
                acc_cyc = cyc;
                acc_flag[g] = 1'b1;
                resp_seen = 1'b0;
            end
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", DW'(rsp_valid), '0);
                end else begin
                    if (!resp_seen) begin
                        chk("latency", DW'(cyc - acc_cyc), DW'(exp_lat));
                        resp_seen = 1'b1;
                    end
                    chk("rsp_id", DW'(rsp_id), DW'(q[0].id));
                    chk("rsp_rx", rsp_rx, q[0].rx);
                    chk("rsp_ry", rsp_ry, q[0].ry);
                    chk("rsp_err", DW'(rsp_err), DW'(q[0].err));
                    if (rsp_ready) begin
                        last_id  = rsp_id;
                        last_rx  = rsp_rx;
                        last_ry  = rsp_ry;
                        last_err = rsp_err;
                        order.push_back(int'(rsp_id));
                        last_m = q[0].id;
                        void'(q.pop_front());
                        pops++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (acc_flag[i]) begin
                acc_flag[i] = 1'b0;
                req_valid[i] = 1'b0;
            end else if (req_valid[i] && $urandom_range(99) < p_drop) begin
                req_valid[i] = 1'b0;
            end
            if (!req_valid[i] && remain[i] > 0 && $urandom_range(99) < p_req) begin
                opx[i] = rnd();
                opy[i] = rnd();
                opk[i] = rnd();
                req_valid[i] = 1'b1;
                remain[i]--;
            end
        end
        rsp_ready = ($urandom_range(99) < p_rdy);
    endtask

    task automatic do_reset(input int n);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", DW'(req_ready), '0);
        chk("rst_core_in_valid", DW'(core_in_valid), '0);
        chk("rst_rsp_valid", DW'(rsp_valid), '0);
        chk("rst_rsp_err", DW'(rsp_err), '0);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_rsp_id", DW'(rsp_id), '0);
        chk("rst_core_px", core_px, '0);
        chk("rst_core_py", core_py, '0);
        chk("rst_core_k", core_k, '0);
        chk("rst_rsp_rx", rsp_rx, '0);
        chk("rst_rsp_ry", rsp_ry, '0);
        req_valid = 2'b00;
        q.delete();
        issue_exp = 1'b0;
        acc_flag = '{1'b0, 1'b0};
        last_m = 1'b1;
        resp_seen = 1'b1;
        remain = '{0, 0};
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_until_pops(input int n, input int lim);
        int k = 0;
        while (pops < n && k < lim) begin
            tick();
            k++;
        end
        chk("wait_pops", DW'(pops), DW'(n));
    endtask

    initial begin
        int vcnt;
        for (int i = 0; i < 2; i++) begin
            opx[i] = '0;
            opy[i] = '0;
            opk[i] = '0;
        end
        do_reset(3);

        // Single request with known operands.
        opx[0] = DW'(1);
        opy[0] = DW'(2);
        opk[0] = DW'(3);
        req_valid[0] = 1'b1;
        p_rdy = 100;
        run_until_pops(1, 60);
        chk("single_id", DW'(last_id), '0);
        chk("single_rx", last_rx, DW'(2));
        chk("single_ry", last_ry, DW'(1));
        chk("single_pulses", DW'(pulses), DW'(1));

        // Both requesters from reset alternate 0,1,0,1.
        do_reset(3);
        order.delete();
        remain = '{2, 2};
        p_req = 100;
        p_drop = 0;
        run_until_pops(pops + 4, 200);
        for (int i = 0; i < 4; i++)
            chk("rr_order", DW'(order.size() > i ? order[i] : -1), DW'(i % 2));

        // Response back-pressure with a competing request waiting.
        remain = '{1, 1};
        p_rdy = 0;
        vcnt = 0;
        while (!rsp_valid && vcnt < 60) begin
            tick();
            vcnt++;
        end
        chk("stall_rsp_seen", DW'(rsp_valid), DW'(1));
        repeat (20) tick();
        chk("stall_rsp_held", DW'(rsp_valid), DW'(1));
        chk("stall_ready_low", DW'(req_ready), '0);
        p_rdy = 100;
        run_until_pops(pops + 2, 100);

        // Reset in the middle of BUSY; the stale core result must be dropped.
        remain = '{1, 0};
        p_req = 100;
        repeat (5) tick();
        chk("busy_before_rst", DW'(busy), DW'(1));
        do_reset(3);
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_valid) vcnt++;
        end
        chk("stale_no_rsp", DW'(vcnt), '0);

        // Randomized traffic with withdrawals and back-pressure.
        remain = '{30, 30};
        p_req = 40;
        p_drop = 10;
        p_rdy = 60;
        vcnt = 0;
        while ((remain[0] > 0 || remain[1] > 0 || req_valid != 2'b00 ||
                q.size() > 0 || busy) && vcnt < 5000) begin
            tick();
            vcnt++;
        end
        chk("random_drained", DW'(q.size()), '0);
        p_drop = 0;
        p_rdy = 100;

        // Core never answers.
        core_dead = 1'b1;
        opx[0] = rnd();
        opy[0] = rnd();
        opk[0] = rnd();
        req_valid[0] = 1'b1;
`ifdef DP_ARB_TIMEOUT_EN
        exp_lat = 52;
        run_until_pops(pops + 1, 100);
        chk("timeout_err", DW'(last_err), DW'(1));
        chk("timeout_rx", last_rx, '0);
        exp_lat = 12;
        core_dead = 1'b0;
`else
        vcnt = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (rsp_valid) vcnt++;
        end
        chk("no_timeout_rsp", DW'(vcnt), '0);
        chk("no_timeout_busy", DW'(busy), DW'(1));
        core_dead = 1'b0;
        do_reset(3);
`endif
        repeat (5) tick();
        chk("final_queue", DW'(q.size()), '0);
        chk("final_busy", DW'(busy), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
